atom_via: RTL
=============

ATOM_VIA -- requirements
Module: atom_via

Interface
REQ-001 SHALL have parameter TICK_DIV, default 25, meaning clk cycles per timer tick (25 MHz clk gives 1 MHz VIA tick); legal range 1..255.
REQ-002 SHALL have parameter PB7_TIMER, default 1, meaning 1 allows ACR[7] to drive PB7 from T1, 0 ties that feature off.
REQ-003 SHALL have ports: clk in 1, system clock; reset in 1, synchronous active-high reset, one clock only.
REQ-004 SHALL have ports: cs in 1, register select; rnw in 1, 1=read, 0=write; address in 4, register index; din in 8, write data; dout out 8, read data.
REQ-005 SHALL have ports: pa_in in 8; pa_out out 8; pa_oe out 8 (=DDRA); pb_in in 8; pb_out out 8; pb_oe out 8 (=DDRB); irq_n out 1, active-low interrupt.

Function
REQ-006 SHALL decode registers: 0 ORB/IRB, 1 ORA/IRA, 2 DDRB, 3 DDRA, 4 T1C-L, 5 T1C-H, 6 T1L-L, 7 T1L-H, 8 T2C-L, 9 T2C-H, B ACR, D IFR, E IER, F ORA (alias of 1); A and C read 0x00, writes ignored.
REQ-007 SHALL make dout combinational from address, valid in the same cycle; dout is 0x00 when cs=0.
REQ-008 SHALL commit writes on the clk edge with cs=1, rnw=0; read side effects on the clk edge with cs=1, rnw=1.
REQ-009 SHALL read ports as (ORx & DDRx) | (pin_in & ~DDRx) per bit; pa_out=ORA, pb_out=ORB, except PB7 under REQ-016.
REQ-010 SHALL generate a one-cycle tick every TICK_DIV clk cycles from a free-running prescaler cleared by reset.
REQ-011 SHALL give T1 a 16-bit counter and 16-bit latch: write 4 or 6 loads latch low; write 7 loads latch high and clears IFR[6]; write 5 loads latch high, copies latch into counter, clears IFR[6], and arms T1.
REQ-012 SHALL decrement T1 by 1 on each tick; on a tick with counter=0x0000, sets IFR[6] if armed; ACR[6]=1 (free-run) reloads counter from latch and stays armed; ACR[6]=0 (one-shot) wraps counter to 0xFFFF and disarms.
REQ-013 SHALL clear IFR[6] on a read of register 4; reads of 4/5 return counter low/high, reads of 6/7 return latch low/high.
REQ-014 SHALL give T2 a 16-bit one-shot counter: write 8 loads an 8-bit low latch; write 9 loads counter {din, latch}, clears IFR[5], and arms; the zero tick sets IFR[5] if armed, wraps to 0xFFFF, and disarms; a read of 8 clears IFR[5].
REQ-015 SHALL give a counter-load write precedence over a tick in the same cycle: the loaded value is kept and no decrement occurs.
REQ-016 SHALL, when PB7_TIMER=1 and ACR[7]=1, force pb_oe[7]=1 and drive pb_out[7] from T1 PB7 state: cleared on a write to 5, toggled on each T1 zero tick in free-run, set on the one-shot zero tick.
REQ-017 SHALL make IFR[7] = |(IFR[6:0] & IER[6:0]); a write to D clears each IFR[6:0] bit where din=1.
REQ-018 SHALL give a flag set precedence over a clear in the same cycle.
REQ-019 SHALL, on a write to E, set IER[6:0] bits where din=1 if din[7]=1 and clear them if din[7]=0; a read of E returns {1'b1, IER[6:0]}.
REQ-020 SHALL drive irq_n = ~IFR[7], registered-free (combinational from flag state).
REQ-021 SHALL hold IFR[4:0] at 0 and ignore IER[4:0] writes, with no CA/CB or shift register.

Reset
REQ-022 SHALL reset all of: ORA, ORB, DDRA, DDRB, ACR, IFR, IER to 0x00; pa_out, pa_oe, pb_out, pb_oe to 0x00; irq_n to 1.
REQ-023 SHALL reset T1 and T2 to disarmed with counters and latches at 0x0000, the prescaler to 0, and the PB7 state to 1.
REQ-024 SHALL abort any timer in progress when reset is asserted mid-count, with no flag set on the reset cycle.

Verification
REQ-025 SHALL cover: DDRA=0x0F, ORA=0xA5, pa_in=0x3C -> read reg 1 = 0x35, pa_out=0xA5, pa_oe=0x0F.
REQ-026 SHALL cover: TICK_DIV=25, ACR=0x00, IER=0xC0, write T1 latch low 0x03 then 5=0x00 -> irq_n falls after 4 ticks (100 clk ±25); read reg 4 -> irq_n=1; no second IRQ over 70000 ticks.
REQ-027 SHALL cover: ACR=0x40, T1=0x0004 -> IFR[6] sets every 5 ticks; with ACR=0xC0, pb_out[7] toggles at each period.
REQ-028 SHALL cover: T2 write 8=0x02, 9=0x00, IER=0xA0 -> IFR=0xA0 after 3 ticks; write D=0x20 -> IFR=0x00, irq_n=1.
REQ-029 SHALL cover: a write to 5 on the exact tick cycle -> the counter equals the new latch value, not decremented.
REQ-030 SHALL cover: reset asserted for one cycle mid-count with IFR=0xC0 -> next cycle IFR=0x00, irq_n=1, and the timer does not fire.

Source files
------------

// File: rtl/atom_via.sv
// Reduced 6522-style VIA: two 8-bit ports, T1 (one-shot / free-run with PB7 output), T2 one-shot,
// and an IFR/IER interrupt block. Timers count on a prescaled tick.
module atom_via #(
  parameter int TICK_DIV  = 25,
  parameter int PB7_TIMER = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic       rnw,
  input  logic [3:0] address,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic [7:0] pa_in,
  output logic [7:0] pa_out,
  output logic [7:0] pa_oe,
  input  logic [7:0] pb_in,
  output logic [7:0] pb_out,
  output logic [7:0] pb_oe,
  output logic       irq_n
);
  localparam logic [7:0] PRE_MAX = 8'(TICK_DIV - 1);

  logic [7:0]  r_pre, r_ora, r_orb, r_ddra, r_ddrb, r_acr;
  logic [15:0] r_t1c, r_t1l, r_t2c;
  logic [7:0]  r_t2l;
  logic        r_t1_arm, r_t2_arm, r_pb7;
  logic [1:0]  r_ifr, r_ier;  // bit1 = T1 (IFR[6]), bit0 = T2 (IFR[5])

  logic w_tick, w_wr, w_rd, w_ld_t1, w_ld_t2, w_t1_zero, w_t2_zero;
  logic w_t1_fire, w_t2_fire, w_t1_clr, w_t2_clr, w_irq, w_pb7_mode;

  assign w_tick    = (r_pre == PRE_MAX);
  assign w_wr      = cs & ~rnw;
  assign w_rd      = cs & rnw;
  assign w_ld_t1   = w_wr && (address == 4'h5);
  assign w_ld_t2   = w_wr && (address == 4'h9);
  assign w_t1_zero = (r_t1c == 16'h0000);
  assign w_t2_zero = (r_t2c == 16'h0000);
  // A counter load in the same cycle as a tick wins: no decrement, no zero event.
  assign w_t1_fire = w_tick & ~w_ld_t1 & w_t1_zero & r_t1_arm;
  assign w_t2_fire = w_tick & ~w_ld_t2 & w_t2_zero & r_t2_arm;
  assign w_t1_clr  = w_ld_t1 || (w_wr && address == 4'h7) || (w_rd && address == 4'h4) ||
                     (w_wr && address == 4'hD && din[6]);
  assign w_t2_clr  = w_ld_t2 || (w_rd && address == 4'h8) || (w_wr && address == 4'hD && din[5]);
  assign w_irq     = |(r_ifr & r_ier);
  assign w_pb7_mode = (PB7_TIMER != 0) && r_acr[7];

  always_ff @(posedge clk) begin
    if (reset) r_pre <= 8'd0;
    else       r_pre <= w_tick ? 8'd0 : r_pre + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ora <= 8'h00; r_orb <= 8'h00; r_ddra <= 8'h00; r_ddrb <= 8'h00;
      r_acr <= 8'h00; r_ier <= 2'b00; r_ifr <= 2'b00;
    end else begin
      if (w_wr) begin
        case (address)
          4'h0:        r_orb  <= din;
          4'h1, 4'hF:  r_ora  <= din;
          4'h2:        r_ddrb <= din;
          4'h3:        r_ddra <= din;
          4'hB:        r_acr  <= din;
          4'hE:        r_ier  <= din[7] ? (r_ier | din[6:5]) : (r_ier & ~din[6:5]);
          default: ;
        endcase
      end
      // Set beats clear when both land on the same edge.
      r_ifr[1] <= w_t1_fire | (r_ifr[1] & ~w_t1_clr);
      r_ifr[0] <= w_t2_fire | (r_ifr[0] & ~w_t2_clr);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_t1c <= 16'h0000; r_t1l <= 16'h0000; r_t1_arm <= 1'b0; r_pb7 <= 1'b1;
    end else begin
      if (w_wr && (address == 4'h4 || address == 4'h6)) r_t1l[7:0]  <= din;
      if (w_wr && (address == 4'h5 || address == 4'h7)) r_t1l[15:8] <= din;
      if (w_ld_t1) begin
        r_t1c    <= {din, r_t1l[7:0]};
        r_t1_arm <= 1'b1;
        r_pb7    <= 1'b0;
      end else if (w_tick) begin
        if (w_t1_zero) begin
          if (r_t1_arm) r_pb7 <= r_acr[6] ? ~r_pb7 : 1'b1;
          if (r_acr[6]) r_t1c <= r_t1l;
          else begin
            r_t1c    <= 16'hFFFF;
            r_t1_arm <= 1'b0;
          end
        end else begin
          r_t1c <= r_t1c - 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_t2c <= 16'h0000; r_t2l <= 8'h00; r_t2_arm <= 1'b0;
    end else begin
      if (w_wr && address == 4'h8) r_t2l <= din;
      if (w_ld_t2) begin
        r_t2c    <= {din, r_t2l};
        r_t2_arm <= 1'b1;
      end else if (w_tick) begin
        if (w_t2_zero) begin
          r_t2c    <= 16'hFFFF;
          r_t2_arm <= 1'b0;
        end else begin
          r_t2c <= r_t2c - 16'd1;
        end
      end
    end
  end

  always_comb begin
    dout = 8'h00;
    if (cs) begin
      case (address)
        4'h0:       dout = (r_orb & r_ddrb) | (pb_in & ~r_ddrb);
        4'h1, 4'hF: dout = (r_ora & r_ddra) | (pa_in & ~r_ddra);
        4'h2:       dout = r_ddrb;
        4'h3:       dout = r_ddra;
        4'h4:       dout = r_t1c[7:0];
        4'h5:       dout = r_t1c[15:8];
        4'h6:       dout = r_t1l[7:0];
        4'h7:       dout = r_t1l[15:8];
        4'h8:       dout = r_t2c[7:0];
        4'h9:       dout = r_t2c[15:8];
        4'hB:       dout = r_acr;
        4'hD:       dout = {w_irq, r_ifr, 5'b00000};
        4'hE:       dout = {1'b1, r_ier, 5'b00000};
        default:    dout = 8'h00;
      endcase
    end
  end

  assign pa_out = r_ora;
  assign pa_oe  = r_ddra;
  assign pb_out = {w_pb7_mode ? r_pb7 : r_orb[7], r_orb[6:0]};
  assign pb_oe  = {r_ddrb[7] | w_pb7_mode, r_ddrb[6:0]};
  assign irq_n  = ~w_irq;
endmodule
